// File: rtl/reg_bank_pkg.sv
// Shared definitions for the Avalon-MM register bank: address offsets of the
// status registers above the general registers, decode select codes and the
// byte-lane mask helper used by every byteenable-gated write.
package reg_bank_pkg;

   // Offsets added to NUM_REGS to locate the status registers
   localparam int DIRTY_OFS    = 0;
   localparam int IRQ_MASK_OFS = 1;

   // Widest supported register is 64 bits, i.e. eight byte lanes
   localparam int MAX_BYTES = 8;

   // Which storage element a decoded address selects
   typedef enum logic [1:0] {
      SEL_NONE     = 2'd0,
      SEL_REG      = 2'd1,
      SEL_DIRTY    = 2'd2,
      SEL_IRQ_MASK = 2'd3
   } sel_e;

   // Expand per-byte enables into a per-bit mask; callers size-cast the
   // result down to their own data width.
   function automatic logic [8*MAX_BYTES-1:0] byte_mask(input logic [MAX_BYTES-1:0] be);
      logic [8*MAX_BYTES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/reg_bank_word.sv
// One general-purpose register of the bank. A write updates only the enabled
// byte lanes and always raises a one-cycle write strobe, even when no lane is
// enabled, so software can use an empty write as a pure notification.
module reg_bank_word
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   writedata,
   output logic [DATA_W-1:0]   q,
   output logic                wr_pulse
);

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] lane_mask;
   logic              pulse_q;
   logic              pulse_d;

   // Merge enabled byte lanes of the write data into the held value
   always_comb begin
      lane_mask = DATA_W'(byte_mask(MAX_BYTES'(byteenable)));
      data_d    = data_q;
      pulse_d   = wr_en;
      if (wr_en) begin
         data_d = (data_q & ~lane_mask) | (writedata & lane_mask);
      end
   end

   // Register contents and write strobe, cleared by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         data_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         pulse_q <= pulse_d;
      end
   end

   assign q        = data_q;
   assign wr_pulse = pulse_q;

endmodule

// File: rtl/reg_bank_avalon_interface.sv
// Avalon-MM slave register bank: NUM_REGS general registers exported on Q,
// a DIRTY status register (bit k set by any write to register k, cleared by
// writing 1) and, when REG_BANK_IRQ_EN is defined, an IRQ_MASK register that
// drives a registered interrupt from the masked DIRTY bits. Without the macro
// the IRQ_MASK address is unmapped and irq is constant 0.
// Reads have a fixed latency of one cycle.
module reg_bank_avalon_interface
   import reg_bank_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS + 2)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       chipselect,
   input  logic                       read,
   input  logic                       write,
   input  logic [ADDR_W-1:0]          address,
   input  logic [DATA_W/8-1:0]        byteenable,
   input  logic [DATA_W-1:0]          writedata,
   output logic [DATA_W-1:0]          readdata,
   output logic                       readdatavalid,
   output logic [NUM_REGS*DATA_W-1:0] Q,
   output logic [NUM_REGS-1:0]        wr_pulse,
   output logic                       irq
);

   logic                wr_acc;
   logic                rd_acc;
   sel_e                sel;
   logic [NUM_REGS-1:0] reg_wr_en;
   logic [DATA_W-1:0]   lane_mask;
   logic [DATA_W-1:0]   word_q [NUM_REGS];
   logic [DATA_W-1:0]   rd_val;

   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   rdata_d;
   logic                rvalid_q;
   logic                rvalid_d;
   logic [NUM_REGS-1:0] dirty_q;
   logic [NUM_REGS-1:0] dirty_d;
`ifdef REG_BANK_IRQ_EN
   logic [NUM_REGS-1:0] irq_mask_q;
   logic [NUM_REGS-1:0] irq_mask_d;
   logic                irq_q;
   logic                irq_d;
`endif

   // Bus acceptance and address decode; a simultaneous read and write is a write
   always_comb begin
      wr_acc    = chipselect & write;
      rd_acc    = chipselect & read & ~write;
      lane_mask = DATA_W'(byte_mask(MAX_BYTES'(byteenable)));
      sel       = SEL_NONE;
      if (int'(address) < NUM_REGS) begin
         sel = SEL_REG;
      end else if (int'(address) == NUM_REGS + DIRTY_OFS) begin
         sel = SEL_DIRTY;
      end
`ifdef REG_BANK_IRQ_EN
      else if (int'(address) == NUM_REGS + IRQ_MASK_OFS) begin
         sel = SEL_IRQ_MASK;
      end
`endif
      reg_wr_en = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         reg_wr_en[k] = wr_acc && (sel == SEL_REG) && (int'(address) == k);
      end
   end

   // General registers, each with its own lane merge and write strobe
   for (genvar k = 0; k < NUM_REGS; k++) begin : g_word
      reg_bank_word #(
         .DATA_W(DATA_W)
      ) u_word (
         .clock     (clock),
         .reset     (reset),
         .wr_en     (reg_wr_en[k]),
         .byteenable(byteenable),
         .writedata (writedata),
         .q         (word_q[k]),
         .wr_pulse  (wr_pulse[k])
      );
      assign Q[k*DATA_W +: DATA_W] = word_q[k];
   end

   // Read mux over general registers and status registers; unmapped reads give 0
   always_comb begin
      rd_val = '0;
      unique case (sel)
         SEL_REG: begin
            for (int k = 0; k < NUM_REGS; k++) begin
               if (int'(address) == k) begin
                  rd_val = word_q[k];
               end
            end
         end
         SEL_DIRTY:    rd_val = DATA_W'(dirty_q);
`ifdef REG_BANK_IRQ_EN
         SEL_IRQ_MASK: rd_val = DATA_W'(irq_mask_q);
`else
         SEL_IRQ_MASK: rd_val = '0;
`endif
         default:      rd_val = '0;
      endcase
   end

   // Next state for read return path and status registers
   always_comb begin
      rvalid_d = rd_acc;
      rdata_d  = rd_acc ? rd_val : rdata_q;
      // A register write sets its dirty bit; a DIRTY write clears ones.
      // Both cannot happen in one cycle since only one address is decoded.
      dirty_d  = dirty_q | reg_wr_en;
      if (wr_acc && (sel == SEL_DIRTY)) begin
         dirty_d = dirty_q & ~NUM_REGS'(writedata & lane_mask);
      end
`ifdef REG_BANK_IRQ_EN
      irq_mask_d = irq_mask_q;
      if (wr_acc && (sel == SEL_IRQ_MASK)) begin
         irq_mask_d = (irq_mask_q & ~NUM_REGS'(lane_mask))
                    | NUM_REGS'(writedata & lane_mask);
      end
      irq_d = |(dirty_q & irq_mask_q);
`endif
   end

   // State registers; reset wins over any bus activity in the same cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         rdata_q    <= '0;
         rvalid_q   <= 1'b0;
         dirty_q    <= '0;
`ifdef REG_BANK_IRQ_EN
         irq_mask_q <= '0;
         irq_q      <= 1'b0;
`endif
      end else begin
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         dirty_q    <= dirty_d;
`ifdef REG_BANK_IRQ_EN
         irq_mask_q <= irq_mask_d;
         irq_q      <= irq_d;
`endif
      end
   end

   // A read whose return cycle coincides with reset is dropped
   assign readdatavalid = rvalid_q & ~reset;
   assign readdata      = rdata_q;

`ifdef REG_BANK_IRQ_EN
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_reg_bank_avalon_interface.sv
// Directed bench for reg_bank_avalon_interface (default parameters). Reads
// push their expected data and return cycle into a scoreboard; a monitor pops
// and checks whenever readdatavalid is seen. Other outputs are checked inline.
module tb_reg_bank_avalon_interface;

   logic         clk;
   logic         reset;
   logic         chipselect;
   logic         read;
   logic         write;
   logic [3:0]   address;
   logic [3:0]   byteenable;
   logic [31:0]  writedata;
   logic [31:0]  readdata;
   logic         readdatavalid;
   logic [255:0] Q;
   logic [7:0]   wr_pulse;
   logic         irq;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   typedef struct {
      logic [31:0] data;
      int          due;
   } exp_t;
   exp_t sb[$];

   reg_bank_avalon_interface dut (
      .clock        (clk),
      .reset        (reset),
      .chipselect   (chipselect),
      .read         (read),
      .write        (write),
      .address      (address),
      .byteenable   (byteenable),
      .writedata    (writedata),
      .readdata     (readdata),
      .readdatavalid(readdatavalid),
      .Q            (Q),
      .wr_pulse     (wr_pulse),
      .irq          (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (readdatavalid) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rdv: readdatavalid=1 readdata=%08h at cycle %0d, no read outstanding", readdata, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (readdata !== e.data || cyc != e.due) begin
               n_fail++;
               $display("FAIL read_data: got %08h at cycle %0d, expected %08h at cycle %0d", readdata, cyc, e.data, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         n_tests++;
         n_fail++;
         e = sb.pop_front();
         $display("FAIL read_missing: readdatavalid=0 at cycle %0d, expected %08h at cycle %0d", cyc, e.data, e.due);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic idle();
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic cs, input logic rd, input logic wr,
                      input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      chipselect = cs;
      read       = rd;
      write      = wr;
      address    = a;
      byteenable = be;
      writedata  = d;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      read       = 1'b0;
      write      = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      bus(1'b1, 1'b0, 1'b1, a, be, d);
   endtask

   task automatic rd(input logic [3:0] a, input logic [31:0] exp);
      sb.push_back('{data: exp, due: cyc + 1});
      bus(1'b1, 1'b1, 1'b0, a, 4'h0, 32'h0);
   endtask

   function automatic logic [31:0] qw(input int k);
      return Q[k*32 +: 32];
   endfunction

   initial begin
      reset      = 1'b1;
      chipselect = 1'b1;   // read held during reset must not return data
      read       = 1'b1;
      write      = 1'b0;
      address    = 4'd2;
      byteenable = 4'hF;
      writedata  = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_readdata", 64'(readdata), 64'h0);
      chk("rst_rdv", 64'(readdatavalid), 64'h0);
      chk("rst_q_zero", 64'(|Q), 64'h0);
      chk("rst_wr_pulse", 64'(wr_pulse), 64'h0);
      chk("rst_irq", 64'(irq), 64'h0);
      chipselect = 1'b0;
      read       = 1'b0;
      reset      = 1'b0;
      idle();

      // Full write, strobe width, read back, readdata hold
      wr(4'd2, 4'hF, 32'hDEAD_BEEF);
      chk("wr2_pulse", 64'(wr_pulse), 64'h04);
      chk("wr2_q", 64'(qw(2)), 64'hDEAD_BEEF);
      idle();
      chk("wr2_pulse_off", 64'(wr_pulse), 64'h00);
      rd(4'd2, 32'hDEAD_BEEF);
      idle();
      chk("hold_rdv", 64'(readdatavalid), 64'h0);
      chk("hold_readdata", 64'(readdata), 64'hDEAD_BEEF);

      // Partial byte-lane write: lanes 0 and 2 replaced
      wr(4'd3, 4'hF, 32'h1122_3344);
      wr(4'd3, 4'b0101, 32'hAABB_CCDD);
      chk("be_q3", 64'(qw(3)), 64'h11BB_33DD);
      rd(4'd3, 32'h11BB_33DD);

      // DIRTY set / write-1-to-clear
      rd(4'd8, 32'h0000_000C);
      wr(4'd8, 4'hF, 32'h0000_00FF);
      rd(4'd8, 32'h0);
      wr(4'd0, 4'hF, 32'h0000_0001);
      wr(4'd5, 4'hF, 32'h0000_0005);
      rd(4'd8, 32'h0000_0021);
      wr(4'd8, 4'hF, 32'h0000_0001);
      rd(4'd8, 32'h0000_0020);
      wr(4'd8, 4'h0, 32'h0000_00FF);
      rd(4'd8, 32'h0000_0020);

      // Write with no lanes enabled: strobe and dirty, data unchanged
      wr(4'd6, 4'h0, 32'hFFFF_FFFF);
      chk("be0_pulse", 64'(wr_pulse), 64'h40);
      chk("be0_q6", 64'(qw(6)), 64'h0);
      rd(4'd8, 32'h0000_0060);
      wr(4'd8, 4'h1, 32'h0000_00FF);
      rd(4'd8, 32'h0);

`ifdef REG_BANK_IRQ_EN
      wr(4'd9, 4'hF, 32'h0000_0020);
      rd(4'd9, 32'h0000_0020);
      wr(4'd5, 4'hF, 32'h0);
      chk("irq_lag", 64'(irq), 64'h0);
      idle();
      chk("irq_set", 64'(irq), 64'h1);
      wr(4'd8, 4'hF, 32'h0000_0020);
      chk("irq_hold", 64'(irq), 64'h1);
      idle();
      chk("irq_clr", 64'(irq), 64'h0);
`else
      rd(4'd9, 32'h0);
      wr(4'd9, 4'hF, 32'h0000_00FF);
      chk("mask_unmapped_pulse", 64'(wr_pulse), 64'h0);
      wr(4'd5, 4'hF, 32'h0);
      idle();
      idle();
      chk("irq_tied", 64'(irq), 64'h0);
      wr(4'd8, 4'hF, 32'h0000_00FF);
`endif

      // Read+write together: write wins, no read return
      bus(1'b1, 1'b1, 1'b1, 4'd1, 4'hF, 32'h1234_5678);
      chk("rw_pulse", 64'(wr_pulse), 64'h02);
      rd(4'd1, 32'h1234_5678);
      // chipselect low: everything ignored
      bus(1'b0, 1'b1, 1'b1, 4'd1, 4'hF, 32'h0);
      chk("cs_low_pulse", 64'(wr_pulse), 64'h0);
      rd(4'd1, 32'h1234_5678);
      // Unmapped addresses
      rd(4'd10, 32'h0);
      rd(4'd15, 32'h0);
      wr(4'd12, 4'hF, 32'hFFFF_FFFF);
      chk("unmapped_pulse", 64'(wr_pulse), 64'h0);

      // Reset arriving while a read is returning
      wr(4'd4, 4'hF, 32'hFFFF_FFFF);
      chk("wr4_q", 64'(qw(4)), 64'hFFFF_FFFF);
      bus(1'b1, 1'b1, 1'b0, 4'd4, 4'h0, 32'h0);
      reset = 1'b1;
      #1;
      chk("rst_kill_rdv", 64'(readdatavalid), 64'h0);
      @(posedge clk);
      #1;
      chk("rst2_q_zero", 64'(|Q), 64'h0);
      chk("rst2_rdv", 64'(readdatavalid), 64'h0);
      chk("rst2_readdata", 64'(readdata), 64'h0);
      reset = 1'b0;
      idle();
      rd(4'd4, 32'h0);
      rd(4'd8, 32'h0);

      idle();
      idle();
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
